// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// instruction type codes and the default reset PC.
package instr_sequencer_pkg;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_COMMIT  = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH   = S_FETCH,
        ST_DECODE  = S_DECODE,
        ST_EXECUTE = S_EXECUTE,
        ST_MEM     = S_MEM,
        ST_WB      = S_WB,
        ST_COMMIT  = S_COMMIT,
        ST_HALT    = S_HALT,
        ST_FAULT   = S_FAULT
    } state_e;

    // Type A: ALU only, Type B: ALU + register write, Type C: data memory access.
    typedef enum logic [1:0] {
        TYPE_A = 2'd0,
        TYPE_B = 2'd1,
        TYPE_C = 2'd2
    } instr_type_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic instr_type_e instr_type(input logic mem_op, input logic wb_op);
        if (mem_op) begin
            return TYPE_C;
        end
        return wb_op ? TYPE_B : TYPE_A;
    endfunction

endpackage

// File: rtl/instr_sequencer_bus_wait_timer.sv
// Counts cycles spent waiting on a memory ack; flags a timeout on the last
// allowed cycle unless the ack arrives in that same cycle.
module instr_sequencer_bus_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic timeout
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of completed wait cycles before the current one.
    assign timeout = en && !ack && (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, optional memory and
// writeback, then commit of the next PC. Owns the PC, IR and retired count.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        dec_en,
    input  logic        dec_halt,
    input  logic        mem_op,
    input  logic        wb_op,
    output logic        alu_en,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_en,
    input  logic [31:0] pc_nxt,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault,
    output state_e      dbg_state
);

    // Handshake: a req stays high from the first cycle of FETCH/MEM until the
    // cycle its ack is seen; an ack counts only in a cycle where its req is high.

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;
    logic        wb_pend_q, wb_pend_d;

    logic        wait_en;
    logic        wait_ack;
    logic        wait_clr;
    logic        wait_timeout;

    assign wait_en  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEM) && dmem_ack);
    assign wait_clr = (state_d != state_q);

    instr_sequencer_bus_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .en     (wait_en),
        .ack    (wait_ack),
        .timeout(wait_timeout)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        wb_pend_d = wb_pend_q;
        imem_req  = 1'b0;
        dec_en    = 1'b0;
        alu_en    = 1'b0;
        dmem_req  = 1'b0;
        rf_we     = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Held low while reset is asserted so no fetch is requested then.
                imem_req = !rst;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (wait_timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                dec_en  = 1'b1;
                state_d = dec_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_en    = 1'b1;
                wb_pend_d = wb_op;
                if (mem_op) begin
                    state_d = ST_MEM;
                end else if (wb_op) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = wb_pend_q ? ST_WB : ST_COMMIT;
                end else if (wait_timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                pc_en = 1'b1;
                if (pc_nxt[1:0] != 2'b00) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d      = pc_nxt;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
            wb_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            wb_pend_q <= wb_pend_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized checks of instr_sequencer against a per-instruction
// model of expected cycle counts, strobes, PC, IR and retired count.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int          WAIT_MAX = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic        dec_en;
    logic        dec_halt = 1'b0;
    logic        mem_op = 1'b0;
    logic        wb_op = 1'b0;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        pc_en;
    logic [31:0] pc_nxt = 32'd0;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        fault;
    state_e      dbg_state;

    always #5 clk = ~clk;

    instr_sequencer #(
        .RESET_PC(RESET_PC),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir        (ir),
        .dec_en    (dec_en),
        .dec_halt  (dec_halt),
        .mem_op    (mem_op),
        .wb_op     (wb_op),
        .alu_en    (alu_en),
        .dmem_req  (dmem_req),
        .dmem_ack  (dmem_ack),
        .rf_we     (rf_we),
        .pc_en     (pc_en),
        .pc_nxt    (pc_nxt),
        .pc        (pc),
        .retired   (retired),
        .halted    (halted),
        .fault     (fault),
        .dbg_state (dbg_state)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic [31:0] m_ir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int strobe_sum();
        return int'(imem_req) + int'(dec_en) + int'(alu_en) + int'(dmem_req) + int'(rf_we) + int'(pc_en);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        dec_halt = 1'b0;
        mem_op = 1'b0;
        wb_op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_pc = RESET_PC;
        m_retired = 32'd0;
        m_ir = 32'd0;
        check("rst state", dbg_state, ST_FETCH);
        check("rst pc", pc, m_pc);
        check("rst ir", ir, m_ir);
        check("rst retired", retired, m_retired);
        check("rst strobes", strobe_sum(), 0);
        check("rst halted", halted, 0);
        check("rst fault", fault, 0);
        rst = 1'b0;
        #1;
    endtask

    // Runs one instruction from the first FETCH cycle: imem acks in FETCH cycle f,
    // dmem acks in MEM cycle m (values above WAIT_MAX mean never).
    task automatic run_instr(input string tag, input int f, input bit halt, input bit mem,
                             input bit wb, input int m, input logic [31:0] nxt);
        int n_imem = 0, n_dec = 0, n_alu = 0, n_dmem = 0, n_rf = 0, n_pc = 0, n_busy = 0;
        int e_imem = 0, e_dec = 0, e_alu = 0, e_dmem = 0, e_rf = 0, e_pc = 0;
        int dmem_at_rf = -1;
        int guard;
        bit done = 0, exp_halt = 0, exp_fault = 0;
        logic [31:0] rdata;
        state_e exp_state;
        rdata = $urandom();
        dec_halt = halt;
        mem_op = mem;
        wb_op = wb;
        pc_nxt = nxt;
        for (guard = 0; guard < 400; guard++) begin
            if (halted || fault || done) break;
            n_imem += int'(imem_req);
            n_dec  += int'(dec_en);
            n_alu  += int'(alu_en);
            n_dmem += int'(dmem_req);
            n_rf   += int'(rf_we);
            n_pc   += int'(pc_en);
            if (strobe_sum() != 0) n_busy++;
            if (rf_we) dmem_at_rf = n_dmem;
            if (pc_en) done = 1;
            if (imem_req) begin
                imem_ack = (n_imem == f);
                imem_rdata = (n_imem == f) ? rdata : $urandom();
            end else begin
                imem_ack = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom();
            end
            dmem_ack = dmem_req ? (n_dmem == m) : ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        check({tag, " bounded"}, 32'(guard < 400), 1);

        if (f > WAIT_MAX) begin
            e_imem = WAIT_MAX;
            exp_fault = 1;
        end else begin
            e_imem = f;
            e_dec = 1;
            m_ir = rdata;
            if (halt) begin
                exp_halt = 1;
            end else begin
                e_alu = 1;
                if (mem && m > WAIT_MAX) begin
                    e_dmem = WAIT_MAX;
                    exp_fault = 1;
                end else begin
                    e_dmem = mem ? m : 0;
                    e_rf = wb ? 1 : 0;
                    e_pc = 1;
                    if (nxt[1:0] != 2'b00) begin
                        exp_fault = 1;
                    end else begin
                        m_pc = nxt;
                        m_retired = m_retired + 32'd1;
                    end
                end
            end
        end
        exp_state = exp_fault ? ST_FAULT : (exp_halt ? ST_HALT : ST_FETCH);

        check({tag, " imem_cycles"}, n_imem, e_imem);
        check({tag, " dec_pulses"}, n_dec, e_dec);
        check({tag, " alu_pulses"}, n_alu, e_alu);
        check({tag, " dmem_cycles"}, n_dmem, e_dmem);
        check({tag, " rf_pulses"}, n_rf, e_rf);
        check({tag, " pc_pulses"}, n_pc, e_pc);
        check({tag, " busy_cycles"}, n_busy, e_imem + e_dec + e_alu + e_dmem + e_rf + e_pc);
        if (e_rf == 1 && mem) check({tag, " rf_after_ack"}, dmem_at_rf, m);
        check({tag, " state"}, dbg_state, exp_state);
        check({tag, " pc"}, pc, m_pc);
        check({tag, " imem_addr"}, imem_addr, m_pc);
        check({tag, " ir"}, ir, m_ir);
        check({tag, " retired"}, retired, m_retired);
        check({tag, " halted"}, halted, 32'(exp_halt));
        check({tag, " fault"}, fault, 32'(exp_fault));
        check({tag, " imem_req"}, imem_req, 32'(exp_state == ST_FETCH));
    endtask

    task automatic idle_check(input string tag, input bit exp_halt, input bit exp_fault);
        int strobes = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            dec_halt = 1'($urandom_range(0, 1));
            mem_op = 1'($urandom_range(0, 1));
            wb_op = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            pc_nxt = $urandom();
            @(negedge clk);
            strobes += strobe_sum();
        end
        check({tag, " idle_strobes"}, strobes, 0);
        check({tag, " idle_pc"}, pc, m_pc);
        check({tag, " idle_ir"}, ir, m_ir);
        check({tag, " idle_retired"}, retired, m_retired);
        check({tag, " idle_halted"}, halted, 32'(exp_halt));
        check({tag, " idle_fault"}, fault, 32'(exp_fault));
    endtask

    initial begin
        logic [31:0] tmp;
        int kind;
        int strobes;

        do_reset();

        run_instr("alu_first", 2, 0, 0, 0, 0, m_pc + 32'd4);
        check("alu_first pc_is_4", pc, 32'h4);
        run_instr("mem_wb", 1, 0, 1, 1, 3, m_pc + 32'd4);
        run_instr("mem_only", 3, 0, 1, 0, 2, m_pc + 32'd8);
        run_instr("wb_only", 1, 0, 0, 1, 0, m_pc + 32'd4);

        for (int i = 0; i < 40; i++) begin
            tmp = $urandom();
            run_instr("rand", $urandom_range(1, WAIT_MAX), 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, WAIT_MAX), tmp & ~32'h3);
        end

        run_instr("final_cycle_ack", WAIT_MAX, 0, 1, 1, WAIT_MAX, m_pc + 32'd4);

        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFF_FFFF;
        check("wrap preload", retired, m_retired);
        run_instr("wrap", 1, 0, 0, 0, 0, m_pc + 32'd4);
        check("wrap zero", retired, 32'd0);

        run_instr("misaligned", 1, 0, 0, 0, 0, 32'h0000_0006);
        idle_check("misaligned", 0, 1);
        do_reset();

        run_instr("pre_halt", 1, 0, 0, 0, 0, m_pc + 32'd4);
        run_instr("halt", 2, 1, 0, 0, 0, m_pc + 32'd4);
        idle_check("halt", 1, 0);
        do_reset();

        run_instr("imem_timeout", WAIT_MAX + 1, 0, 0, 0, 0, m_pc + 32'd4);
        idle_check("imem_timeout", 0, 1);
        do_reset();

        run_instr("dmem_timeout", 1, 0, 1, 1, WAIT_MAX + 1, m_pc + 32'd4);
        idle_check("dmem_timeout", 0, 1);
        do_reset();

        run_instr("pre_midrst", 1, 0, 0, 0, 0, 32'h0000_0100);
        imem_ack = 1'b1;
        imem_rdata = $urandom();
        mem_op = 1'b1;
        wb_op = 1'b1;
        dec_halt = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrst dmem_req_before", dmem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        m_pc = RESET_PC;
        m_retired = 32'd0;
        m_ir = 32'd0;
        check("midrst dmem_req", dmem_req, 0);
        check("midrst pc", pc, m_pc);
        check("midrst state", dbg_state, ST_FETCH);
        check("midrst strobes", strobe_sum(), 0);
        check("midrst retired", retired, m_retired);
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            strobes += int'(rf_we) + int'(pc_en) + int'(dmem_req);
        end
        check("midrst no_late_strobes", strobes, 0);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            kind = $urandom_range(0, 7);
            tmp = $urandom();
            case (kind)
                0: run_instr("mix_halt", $urandom_range(1, WAIT_MAX), 1, 0, 0, 0, tmp & ~32'h3);
                1: run_instr("mix_misal", 1, 0, 0, 1'($urandom_range(0, 1)), 0, tmp | 32'h1);
                2: run_instr("mix_imem_to", WAIT_MAX + 1, 0, 0, 0, 0, tmp & ~32'h3);
                default: run_instr("mix_ok", $urandom_range(1, 4), 0, 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), $urandom_range(1, 4), tmp & ~32'h3);
            endcase
            if (halted || fault) do_reset();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
